// File: rtl/sensor_noise_inject_pkg.sv
// Shared constants for the sensor noise injector: noise modes and LFSR settings.
package sensor_noise_inject_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS      = 2'd0,
    MODE_RANDOM      = 2'd1,
    MODE_SALT_PEPPER = 2'd2,
    MODE_FIXED       = 2'd3
  } noise_mode_e;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'h0001;

  function automatic logic [15:0] fix_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? LFSR_ZERO_SEED : seed;
  endfunction

endpackage

// File: rtl/noise_lfsr.sv
// Free-running Galois LFSR; advances every clock, reloads SEED on reset.
module noise_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter logic [WIDTH-1:0] TAPS  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] lfsr
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= SEED;
    else          lfsr <= {1'b0, lfsr[WIDTH-1:1]} ^ (lfsr[0] ? TAPS : '0);
  end

endmodule

// File: rtl/sensor_noise_inject.sv
// Registered pixel pipeline that overwrites pixels with LFSR-driven noise at
// LFSR-driven gaps; configuration is captured once per frame.
module sensor_noise_inject
  import sensor_noise_inject_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter int          CHANNEL_NUM = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_noise_en,
  input  logic [1:0]                        iv_noise_mode,
  input  logic [15:0]                       iv_gap_mask,
  input  logic [DATA_WIDTH-1:0]             iv_noise_value,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic [15:0]                       ov_noise_cnt
);

  localparam int          CH_BITS  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam logic [15:0] SEED_EFF = fix_seed(LFSR_SEED);

  logic [15:0] lfsr;

  noise_lfsr #(.WIDTH(16), .SEED(SEED_EFF), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .lfsr    (lfsr)
  );

  logic                  fval_d;
  logic                  en_q;
  noise_mode_e           mode_q;
  logic [15:0]           mask_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic [15:0]           gap_cnt;
  logic [15:0]           target;
  logic [15:0]           noise_cnt;

  logic                  frame_start, frame_end, beat, active, inject;
  logic                  en_eff;
  noise_mode_e           mode_eff;
  logic [15:0]           mask_eff, gap_eff, target_eff;
  logic [DATA_WIDTH-1:0] value_eff, noise_val;
  logic [CH_BITS-1:0]    ch_sel;
  logic [15:0]           gap_next, target_next, cnt_base, cnt_next;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_next;

  assign frame_start = i_fval & ~fval_d;
  assign frame_end   = ~i_fval & fval_d;
  assign beat        = i_fval & i_lval;
  assign ch_sel      = (CHANNEL_NUM > 1) ? lfsr[CH_BITS-1:0] : '0;

  // On the frame-start cycle the fresh configuration applies immediately.
  assign en_eff     = frame_start ? i_noise_en                  : en_q;
  assign mode_eff   = frame_start ? noise_mode_e'(iv_noise_mode) : mode_q;
  assign mask_eff   = frame_start ? iv_gap_mask                 : mask_q;
  assign value_eff  = frame_start ? iv_noise_value              : value_q;
  assign gap_eff    = frame_start ? 16'h0000                    : gap_cnt;
  assign target_eff = frame_start ? (lfsr & iv_gap_mask)        : target;
  assign cnt_base   = frame_start ? 16'h0000                    : noise_cnt;

  assign active = en_eff && (mode_eff != MODE_BYPASS);
  assign inject = active && beat && (gap_eff == target_eff);

  always_comb begin
    noise_val = value_eff;
    case (mode_eff)
      MODE_RANDOM:      noise_val = lfsr[DATA_WIDTH-1:0];
      MODE_SALT_PEPPER: noise_val = lfsr[15] ? '1 : '0;
      default:          noise_val = value_eff;
    endcase
  end

  always_comb begin
    pix_next = iv_pix_data;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (inject && (ch_sel == CH_BITS'(c)))
        pix_next[c*DATA_WIDTH +: DATA_WIDTH] = noise_val;
    end
  end

  always_comb begin
    gap_next    = gap_eff;
    target_next = target_eff;
    cnt_next    = cnt_base;
    if (!active) begin
      gap_next = 16'h0000;
    end else if (inject) begin
      gap_next    = 16'h0000;
      target_next = lfsr & mask_eff;
      if (cnt_base != 16'hFFFF) cnt_next = cnt_base + 16'd1;
    end else if (beat) begin
      gap_next = gap_eff + 16'd1;
    end
  end

  // fval_d resets high so a frame already running at reset release is not a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fval_d       <= 1'b1;
      en_q         <= 1'b0;
      mode_q       <= MODE_BYPASS;
      mask_q       <= 16'h0000;
      value_q      <= '0;
      gap_cnt      <= 16'h0000;
      target       <= 16'h0000;
      noise_cnt    <= 16'h0000;
      o_fval       <= 1'b0;
      o_lval       <= 1'b0;
      ov_pix_data  <= '0;
      ov_noise_cnt <= 16'h0000;
    end else begin
      fval_d      <= i_fval;
      en_q        <= en_eff;
      mode_q      <= mode_eff;
      mask_q      <= mask_eff;
      value_q     <= value_eff;
      gap_cnt     <= gap_next;
      target      <= target_next;
      noise_cnt   <= cnt_next;
      o_fval      <= i_fval;
      o_lval      <= i_lval;
      ov_pix_data <= pix_next;
      if (frame_end) ov_noise_cnt <= cnt_next;
    end
  end

endmodule

// File: doc/sensor_noise_inject.md
SENSOR_NOISE_INJECT -- requirements
Module: sensor_noise_inject

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel bit width; legal range 8..16.
REQ-002 Parameter CHANNEL_NUM, default 1, pixels per clock; legal values 1, 2, 4.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_noise_en  input  1  noise injection enable, sampled at frame start.
REQ-007 iv_noise_mode  input  2  0 bypass, 1 random value, 2 salt-pepper, 3 fixed value; sampled at frame start.
REQ-008 iv_gap_mask  input  16  mask applied to the LFSR to form the random gap between injections; sampled at frame start.
REQ-009 iv_noise_value  input  DATA_WIDTH  value injected in mode 3; sampled at frame start.
REQ-010 i_fval  input  1  frame valid.
REQ-011 i_lval  input  1  line valid.
REQ-012 iv_pix_data  input  DATA_WIDTH*CHANNEL_NUM  pixel data, channel 0 in the LSBs.
REQ-013 o_fval  output  1  frame valid, delayed.
REQ-014 o_lval  output  1  line valid, delayed.
REQ-015 ov_pix_data  output  DATA_WIDTH*CHANNEL_NUM  pixel data with noise applied.
REQ-016 ov_noise_cnt  output  16  number of injections in the last completed frame.

Function
REQ-017 o_fval, o_lval and ov_pix_data SHALL be registered with exactly 1 clk of latency relative to the inputs.
REQ-018 LFSR SHALL be a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1 that advances every clk, independent of fval/lval.
REQ-019 Frame start is the cycle in which i_fval=1 and the registered previous i_fval=0.
REQ-020 At frame start the block SHALL latch enable, mode, mask and value; clear gap_cnt and noise count; and load target = lfsr & mask.
REQ-021 Changes to the configuration inputs mid-frame SHALL have no effect until the next frame start.
REQ-022 A beat is a cycle with i_fval=1 and i_lval=1; i_lval is ignored while i_fval=0.
REQ-023 On a beat with injection active (latched enable=1 and mode!=0):
  - if gap_cnt==target: inject on the selected channel, set gap_cnt to 0, and reload target = lfsr & mask;
  - otherwise increment gap_cnt.
REQ-024 gap_cnt and target SHALL hold between beats; a mask of 0 SHALL inject on every beat.
REQ-025 The injected channel SHALL be lfsr[log2(CHANNEL_NUM)-1:0] (always 0 when CHANNEL_NUM=1); all other channels pass through unchanged.
REQ-026 The noise value SHALL be:
  - mode 1: lfsr[DATA_WIDTH-1:0];
  - mode 2: all ones if lfsr[15]=1, else all zeros;
  - mode 3: the latched value.
  All noise values are taken from the LFSR value of the injecting cycle.
REQ-027 When injection is inactive the output SHALL equal the input delayed by 1 clk, and gap_cnt SHALL be held at 0.
REQ-028 The internal noise count SHALL increment once per injection and saturate at 16'hFFFF.
REQ-029 On the falling edge of i_fval, ov_noise_cnt SHALL be loaded with the frame count, including an injection in that same cycle; it holds otherwise.

Reset
REQ-030 While reset_n=0 the block SHALL drive:
  - o_fval=0, o_lval=0, ov_pix_data=0, ov_noise_cnt=0;
  - gap_cnt=0, target=0, latched enable=0, latched mode=0;
  - LFSR=LFSR_SEED.
REQ-031 The registered previous i_fval SHALL reset to 1, so a frame already in progress at reset release is not treated as a frame start; that frame passes through unmodified.
REQ-032 Reset assertion mid-frame SHALL take effect immediately (asynchronously); deassertion is synchronous to clk (handled externally).

Structure
REQ-033 A shared package SHALL hold the mode constants (MODE_BYPASS, MODE_RANDOM, MODE_SALT_PEPPER, MODE_FIXED), the LFSR polynomial tap constant, and the zero-seed substitute value.
REQ-034 The LFSR SHALL be a sub-module noise_lfsr (parameters WIDTH, SEED, TAPS) with ports clk, reset_n and a lfsr value output.

Verification
REQ-035 Mode 0, CHANNEL_NUM=1, ramp 0..63 on one 64-beat line -> output equals input delayed 1 clk; ov_noise_cnt=0 after fval falls.
REQ-036 Mode 3, value 8'h55, mask 0, CHANNEL_NUM=1, 64-beat line -> all 64 output pixels are 8'h55; ov_noise_cnt=64.
REQ-037 Mode 2, DATA_WIDTH=12, mask 16'h000F, 1000 beats -> every altered pixel is 12'hFFF or 12'h000; ov_noise_cnt matches the golden model.
REQ-038 Mode 1, seed 16'hACE1, mask 16'h00FF, CHANNEL_NUM=4; switch mode to 0 mid-frame -> injection positions, channels and values match the golden LFSR model cycle-exactly, and the mode change takes effect only at the next frame.
REQ-039 Assert reset_n mid-line, then release with i_fval still high -> outputs are 0 while reset is asserted; the remainder of the frame passes through with no injection; injection resumes at the next frame start.
REQ-040 Mode 3, mask 0, 70000 beats in one frame -> ov_noise_cnt=16'hFFFF (saturated).
